// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction memory loader
//   Contents: loader state enum, memory geometry localparams, end-of-program sentinel.
package instr_loader_pkg;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] END_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs four bytes, MSB first, into one instruction word
//   Ports:
//     clk, reset     clock and synchronous active-high reset
//     clr            clears byte counter and shift register (new session)
//     push           accept byte_in this cycle
//     byte_in        incoming byte
//     word_out       assembled word; complete while word_ready is high
//     word_ready     high on the cycle of the 4th push
module byte_assembler
   import instr_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              push,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word_out,
   output logic              word_ready
);

   logic [1:0]        cnt_q;
   logic [DATA_W-1:0] sh_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_q <= 2'd0;
         sh_q  <= '0;
      end else if (push) begin
         cnt_q <= cnt_q + 2'd1;
         sh_q  <= {sh_q[DATA_W-9:0], byte_in};
      end
   end

   // On a push, present the word as it stands including this byte, so the
   // completed word is visible in the same cycle as word_ready.
   assign word_out   = push ? {sh_q[DATA_W-9:0], byte_in} : sh_q;
   assign word_ready = push && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream loader for the 64x32 instruction memory
//   Ports:
//     clk, reset           clock and synchronous active-high reset
//     start                one-cycle pulse, begins a load session (IDLE or DONE only)
//     rx_data/rx_valid     incoming byte stream
//     rx_ready             byte accepted this cycle (LOAD only)
//     we/wa/wd             instruction memory write port, one we pulse per word
//     cpu_hold             CPU held in reset while loading
//     done                 session complete (level)
//     word_count           words written this session, 0..DEPTH
module instr_mem_loader
   import instr_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              we,
   output logic [ADDR_W-1:0] wa,
   output logic [DATA_W-1:0] wd,
   output logic              cpu_hold,
   output logic              done,
   output logic [ADDR_W:0]   word_count
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic              session_start;
   logic              push;
   logic [DATA_W-1:0] asm_word;
   logic              word_ready;

   assign session_start = start && (state_q == IDLE || state_q == DONE);
   assign push          = rx_valid && (state_q == LOAD);

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clr        (session_start),
      .push       (push),
      .byte_in    (rx_data),
      .word_out   (asm_word),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD:  if (word_ready) state_d = WRITE;
         // we_q low in WRITE means the sentinel arrived
         WRITE: begin
            if (!we_q || addr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
            else                                       state_d = LOAD;
         end
         DONE:  if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // The write port is loaded on the edge that accepts the 4th byte, so it is
   // stable for the whole WRITE cycle and holds its value afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         word_count <= '0;
         we_q       <= 1'b0;
         wa         <= '0;
         wd         <= '0;
      end else begin
         we_q <= 1'b0;
         if (session_start) begin
            addr_q     <= '0;
            word_count <= '0;
         end
         if (state_q == LOAD && word_ready && asm_word != END_WORD) begin
            we_q <= 1'b1;
            wa   <= addr_q;
            wd   <= asm_word;
         end
         if (state_q == WRITE && we_q) begin
            addr_q     <= addr_q + ADDR_W'(1);
            word_count <= word_count + (ADDR_W + 1)'(1);
         end
      end
   end

   assign we       = we_q;
   assign rx_ready = (state_q == LOAD);
   assign cpu_hold = (state_q == LOAD) || (state_q == WRITE);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
   import instr_loader_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              cpu_hold;
   logic              done;
   logic [ADDR_W:0]   word_count;

   int total = 0;
   int bad   = 0;
   int acc_bytes = 0;
   int writes    = 0;

   logic [ADDR_W-1:0] log_a[$];
   logic [DATA_W-1:0] log_d[$];

   instr_mem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rx_valid && rx_ready) acc_bytes++;
   end

   // Write monitor and invariant checker
   always @(negedge clk) begin
      if (we === 1'b1) begin
         writes++;
         log_a.push_back(wa);
         log_d.push_back(wd);
         chk("we_state", 32'(dut.state_q), 32'(WRITE));
         chk("we_ratio", 32'(writes * 4 <= acc_bytes), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 200) begin
         tick();
         n++;
      end
      if (!rx_ready) begin
         chk("rdy_timeout", 32'd0, 32'd1);
         rx_valid = 1'b0;
      end else begin
         tick();
         rx_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   // After the 4th byte's accepting edge we are in cycle N+1.
   task automatic send_word(input logic [31:0] w, input int maxgap, input logic expect_we);
      for (int i = 0; i < 4; i++)
         send_byte(w[31-8*i -: 8], (i == 3) ? 0 : int'($urandom_range(0, maxgap)));
      chk("we_lat", 32'(we), 32'(expect_we));
      if (expect_we) chk("wd_lat", wd, w);
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask

   task automatic check_case1_image(input string tag);
      chk({tag, "_n"},  32'(log_a.size()), 32'd2);
      chk({tag, "_a0"}, 32'(log_a[0]), 32'd0);
      chk({tag, "_d0"}, log_d[0], 32'h0000_0001);
      chk({tag, "_a1"}, 32'(log_a[1]), 32'd1);
      chk({tag, "_d1"}, log_d[1], 32'h1234_5678);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      tick(); tick();
      chk("rst_ready", 32'(rx_ready), 32'd0);
      chk("rst_we",    32'(we), 32'd0);
      chk("rst_wa",    32'(wa), 32'd0);
      chk("rst_wd",    wd, 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_cnt",   32'(word_count), 32'd0);
      chk("rst_hold",  32'(cpu_hold), 32'd0);
      reset = 1'b0;
      tick();

      // case 1: basic load with sentinel
      clear_log();
      pulse_start();
      chk("c1_hold", 32'(cpu_hold), 32'd1);
      chk("c1_done0", 32'(done), 32'd0);
      send_word(32'h0000_0001, 0, 1'b1);
      send_word(32'h1234_5678, 0, 1'b1);
      send_word(32'hFFFF_FFFF, 0, 1'b0);
      tick();
      check_case1_image("c1");
      chk("c1_cnt",  32'(word_count), 32'd2);
      chk("c1_done", 32'(done), 32'd1);
      chk("c1_hold1", 32'(cpu_hold), 32'd0);

      // case 2: fill all 64 words, start from DONE
      clear_log();
      pulse_start();
      chk("c2_done0", 32'(done), 32'd0);
      chk("c2_cnt0",  32'(word_count), 32'd0);
      for (int i = 0; i < DEPTH; i++) send_word(32'(i), 0, 1'b1);
      tick();
      chk("c2_n",    32'(log_a.size()), 32'd64);
      chk("c2_a0",   32'(log_a[0]), 32'd0);
      chk("c2_a63",  32'(log_a[63]), 32'd63);
      chk("c2_d63",  log_d[63], 32'd63);
      chk("c2_cnt",  32'(word_count), 32'd64);
      chk("c2_done", 32'(done), 32'd1);
      rx_data = 8'h55; rx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("c2_noready", 32'(rx_ready), 32'd0);
         tick();
      end
      rx_valid = 1'b0;
      chk("c2_nowrite", 32'(log_a.size()), 32'd64);

      // case 3: random gaps, same image as case 1
      clear_log();
      pulse_start();
      send_word(32'h0000_0001, 5, 1'b1);
      send_word(32'h1234_5678, 5, 1'b1);
      send_word(32'hFFFF_FFFF, 5, 1'b0);
      tick();
      check_case1_image("c3");
      chk("c3_cnt", 32'(word_count), 32'd2);

      // case 4: reset after 2 bytes of word 1
      clear_log();
      pulse_start();
      send_word(32'hCAFE_F00D, 0, 1'b1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("c4_state", 32'(dut.state_q), 32'(IDLE));
      chk("c4_we",    32'(we), 32'd0);
      chk("c4_hold",  32'(cpu_hold), 32'd0);
      chk("c4_cnt",   32'(word_count), 32'd0);
      tick();
      chk("c4_we1",   32'(we), 32'd0);
      clear_log();
      pulse_start();
      send_word(32'h0BAD_F00D, 0, 1'b1);
      tick();
      chk("c4_n",  32'(log_a.size()), 32'd1);
      chk("c4_a0", 32'(log_a[0]), 32'd0);
      chk("c4_d0", log_d[0], 32'h0BAD_F00D);

      // case 5: start ignored in LOAD, restart from DONE
      reset = 1'b1; tick(); reset = 1'b0;
      clear_log();
      pulse_start();
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      pulse_start();
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      chk("c5_we", 32'(we), 32'd1);
      send_word(32'h0000_0002, 0, 1'b1);
      send_word(32'hFFFF_FFFF, 0, 1'b0);
      tick();
      chk("c5_n",    32'(log_a.size()), 32'd2);
      chk("c5_d0",   log_d[0], 32'hABCD_1234);
      chk("c5_a1",   32'(log_a[1]), 32'd1);
      chk("c5_cnt",  32'(word_count), 32'd2);
      chk("c5_done", 32'(done), 32'd1);
      clear_log();
      pulse_start();
      chk("c5_done0", 32'(done), 32'd0);
      chk("c5_hold",  32'(cpu_hold), 32'd1);
      chk("c5_cnt0",  32'(word_count), 32'd0);
      send_word(32'h7777_7777, 0, 1'b1);
      tick();
      chk("c5_ra0", 32'(log_a[0]), 32'd0);
      chk("c5_rd0", log_d[0], 32'h7777_7777);
      chk("c5_rcnt", 32'(word_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
